// File: rtl/spike_if_pkg.sv
// Shared definitions for the spike-address bus: default widths, idle address
// and the transmit sequencer state encoding.
package spike_if_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam logic [ADDR_W_DEF-1:0] IDLE_ADDR_DEF = 12'hFFF;
    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_CLEAR,
        ST_DONE
    } state_t;

endpackage

// File: rtl/spike_prio_enc.sv
// Combinational lowest-set-bit encoder: idx is the index of the lowest set
// bit of vec, any flags that at least one bit is set.
module spike_prio_enc #(
    parameter int NUM_NEURONS = 10,
    parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
    input  logic [NUM_NEURONS-1:0] vec,
    output logic [IDX_W-1:0]       idx,
    output logic                   any
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = NUM_NEURONS - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/spike_tx.sv
// Spike-address transmitter: serialises one timestep's fired-neuron bitmap onto
// the MAC address bus, lowest index first, then issues the clear strobe.
module spike_tx
    import spike_if_pkg::*;
#(
    parameter int                NUM_NEURONS  = 10,
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter logic [ADDR_W-1:0] IDLE_ADDR    = ADDR_W'(IDLE_ADDR_DEF),
    parameter int                HOLD_CYCLES  = 2,
    parameter int                GAP_CYCLES   = 1,
    parameter int                CLEAR_CYCLES = 3
) (
    input  logic                   CLK_spike_tx,
    input  logic                   RSTn_spike_tx,
    input  logic [NUM_NEURONS-1:0] spike_vec,
    input  logic                   spike_valid,
    output logic                   spike_ready,
    output logic [ADDR_W-1:0]      source_address,
    output logic                   addr_valid,
    output logic                   clear,
    output logic                   ts_done,
    output logic                   busy,
    output logic [15:0]            ts_count
);

    localparam int IDX_W = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535 ||
            GAP_CYCLES < 1 || GAP_CYCLES > 65535 ||
            CLEAR_CYCLES < 1 || CLEAR_CYCLES > 65535) begin : g_bad_cycles
            $error("spike_tx: HOLD/GAP/CLEAR_CYCLES must be in 1..65535");
        end
        if (NUM_NEURONS < 1) begin : g_bad_width
            $error("spike_tx: NUM_NEURONS must be at least 1");
        end
    endgenerate

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_NEURONS-1:0] pend_q, pend_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic                   avalid_q, avalid_d;
    logic                   clear_q, clear_d;
    logic                   done_q, done_d;
    logic [15:0]            ts_count_q, ts_count_d;

    logic [NUM_NEURONS-1:0] enc_in;
    logic [IDX_W-1:0]       enc_idx;
    logic                   enc_any;

    // In IDLE the incoming vector is encoded directly so the first address can
    // be registered on the acceptance edge; afterwards the pending copy is used.
    assign enc_in = (state_q == ST_IDLE) ? spike_vec : pend_q;

    spike_prio_enc #(
        .NUM_NEURONS (NUM_NEURONS),
        .IDX_W       (IDX_W)
    ) u_prio_enc (
        .vec (enc_in),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_ff @(posedge CLK_spike_tx or negedge RSTn_spike_tx) begin
        if (!RSTn_spike_tx) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pend_q     <= '0;
            addr_q     <= IDLE_ADDR;
            avalid_q   <= 1'b0;
            clear_q    <= 1'b0;
            done_q     <= 1'b0;
            ts_count_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            addr_q     <= addr_d;
            avalid_q   <= avalid_d;
            clear_q    <= clear_d;
            done_q     <= done_d;
            ts_count_q <= ts_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (spike_valid) begin
                    pend_d  = spike_vec;
                    cnt_d   = '0;
                    state_d = enc_any ? ST_SEND : ST_CLEAR;
                end
            end
            ST_SEND: begin
                if (cnt_q == HOLD_LAST) begin
                    pend_d  = pend_q & ~(NUM_NEURONS'(1) << enc_idx);
                    cnt_d   = '0;
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = enc_any ? ST_SEND : ST_CLEAR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == CLEAR_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state, so they line up with it.
    always_comb begin
        addr_d     = IDLE_ADDR;
        avalid_d   = 1'b0;
        clear_d    = (state_d == ST_CLEAR);
        done_d     = (state_d == ST_DONE);
        ts_count_d = ts_count_q + ((state_d == ST_DONE) ? 16'd1 : 16'd0);
        if (state_d == ST_SEND) begin
            addr_d   = BASE_ADDR + ADDR_W'(enc_idx);
            avalid_d = 1'b1;
        end
    end

    assign spike_ready    = (state_q == ST_IDLE);
    assign busy           = (state_q != ST_IDLE);
    assign source_address = addr_q;
    assign addr_valid     = avalid_q;
    assign clear          = clear_q;
    assign ts_done        = done_q;
    assign ts_count       = ts_count_q;

endmodule

// File: doc/spike_tx.md
Name: spike_tx

Overview:
- Transmit end of the spike-address bus consumed by the MAC units.
- Takes the fired-neuron vector of one timestep and serialises it onto source_address, one address per fired neuron, lowest index first.
- Then asserts the end-of-timestep clear strobe, which latches and evaluates the MAC accumulations.
- Sits between the neuron-layer spike outputs and the MAC bank. It replaces the free-running clear/address generation with a handshaked, deterministic sequencer.

Parameters:
- NUM_NEURONS, 10, width of spike_vec; one address per bit.
- ADDR_W, 12, source-address width.
- BASE_ADDR, 0, address emitted for spike_vec[0]; bit i emits BASE_ADDR+i, truncated to ADDR_W.
- IDLE_ADDR, 12'hFFF, address driven when no spike is on the bus; must match no MAC source entry.
- HOLD_CYCLES, 2, cycles each spike address is held (>=1).
- GAP_CYCLES, 1, cycles of IDLE_ADDR between consecutive addresses and after the last one (>=1).
- CLEAR_CYCLES, 3, cycles clear is held high (>=1).

Ports:
- CLK_spike_tx  in  1  clock; all state updates on rising edge.
- RSTn_spike_tx  in  1  asynchronous, active-low reset.
- spike_vec  in  NUM_NEURONS  fired-neuron bitmap for one timestep.
- spike_valid  in  1  spike_vec is valid; producer holds vec/valid until accepted.
- spike_ready  out  1  high only in IDLE; acceptance = spike_valid & spike_ready at the clock edge.
- source_address  out  ADDR_W  spike address to the MACs.
- addr_valid  out  1  source_address carries a spike address.
- clear  out  1  end-of-timestep strobe to the MACs.
- ts_done  out  1  one-cycle pulse when the timestep sequence completes.
- busy  out  1  high whenever not in IDLE.
- ts_count  out  16  completed-timestep counter; wraps 16'hFFFF -> 0.

Behaviour:
- Reset (async, takes effect immediately, mid-operation included):
  - state=IDLE, pending vector=0, cycle counter=0.
  - source_address=IDLE_ADDR, addr_valid=0, clear=0, ts_done=0, busy=0, ts_count=0, spike_ready=1.
- All outputs are registered except spike_ready and busy, which are decoded from the registered state.
- States:
  - IDLE: spike_ready=1, bus idle. On acceptance, latch spike_vec into pend. Next state is SEND if pend!=0, else CLEAR (an empty timestep still gets a clear).
  - SEND:
    - Entered with the lowest set bit of pend (index k).
    - source_address=BASE_ADDR+k and addr_valid=1 for exactly HOLD_CYCLES cycles.
    - Bit k of pend is cleared on the last hold cycle. Then go to GAP.
  - GAP:
    - source_address=IDLE_ADDR, addr_valid=0 for GAP_CYCLES cycles.
    - Then go to SEND if pend!=0, else CLEAR.
  - CLEAR: clear=1 for CLEAR_CYCLES cycles; source_address=IDLE_ADDR. Then go to DONE.
  - DONE: one cycle; ts_done=1, ts_count increments (wrapping). Next state is IDLE.
- Latency (acceptance edge = cycle 0):
  - First address appears in cycle 1.
  - The sequence length for n set bits is n*(HOLD+GAP)+CLEAR+1 cycles from cycle 1 to DONE inclusive. spike_ready returns in the following cycle.
- Address never changes while addr_valid=1, so level-sensitive receivers see one stable value per spike.
- clear and addr_valid are never high in the same cycle.
- Each bit is sent exactly once per timestep; duplicates are impossible by construction.
- spike_vec changes while not ready are ignored, since only the latched pend is used.
- spike_valid held high in DONE is not accepted until IDLE, which gives back-to-back timesteps a minimum 1-cycle idle gap.
- All bits set: addresses BASE..BASE+NUM_NEURONS-1 are sent in ascending order.
- BASE_ADDR+i overflow wraps modulo 2^ADDR_W.
- Internal cycle counter is 16 bits; parameters are limited to <=65535, checked by elaboration-time assertion along with the >=1 rules.

Decomposition:
- Package spike_if_pkg: ADDR_W default, IDLE_ADDR constant, state enumeration (IDLE, SEND, GAP, CLEAR, DONE).
- One sub-module, spike_prio_enc: combinational lowest-set-bit encoder with inputs vec[NUM_NEURONS] and outputs idx[$clog2(NUM_NEURONS)] and any.
- The FSM, counters and output registers live in spike_tx.

Test Plan:
1. Reset/idle: hold RSTn low, then release with no valid -> source_address=12'hFFF, addr_valid=0, clear=0, ts_count=0, spike_ready=1 indefinitely.
2. Sparse vector: spike_vec=10'b0000000101 accepted at cycle 0 (HOLD=2, GAP=1, CLEAR=3). Required:
   - addr 0 in cycles 1-2, IDLE_ADDR in 3;
   - addr 2 in cycles 4-5, IDLE_ADDR in 6;
   - clear in 7-9, ts_done in 10, spike_ready in 11, ts_count=1.
3. Empty vector: spike_vec=0 accepted -> no addr_valid; clear in cycles 1-3, ts_done in cycle 4.
4. Full vector with BASE_ADDR=12'hFFE: all 10 bits set -> addresses FFE, FFF, 000..007 in order (wrap checked), 10 hold windows, then a single clear.
5. Back-to-back with a changing input:
   - valid held high with vec=10'b1000000000, changed to 10'b0000000001 during SEND -> first timestep emits only addr 9.
   - Second acceptance occurs in the IDLE cycle after ts_done and emits addr 0.
   - ts_count=2.
6. Mid-operation reset: assert RSTn during SEND of addr 3 -> outputs return to reset values in the same cycle with no clock required. After release, a new vector sends from its own lowest bit and ts_count restarts at 0; ts_count wrap 16'hFFFF -> 0 is checked by forcing 65536 empty timesteps.
